// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX-stage operand forwarding selects and load-use stall control
module forward_hazard_unit #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rt,
    input  logic                       id_uses_rs,
    input  logic                       id_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0]  id_dest,
    input  logic                       id_reg_write,
    input  logic                       id_mem_read,
    input  logic                       flush,
    output logic [1:0]                 forward_a,
    output logic [1:0]                 forward_b,
    output logic                       stall,
    output logic                       pc_write,
    output logic                       ifid_write,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);
    logic [REG_ADDR_WIDTH-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic ex_rw, ex_mr, mem_rw, wb_rw, load_use, bubble;

    // Forward selects (MEM beats WB, $0 never forwards) and load-use detection
    always_comb begin
        forward_a = (mem_rw && mem_dest != '0 && mem_dest == ex_rs) ? 2'd2 :
                    (wb_rw && wb_dest != '0 && wb_dest == ex_rs) ? 2'd1 : 2'd0;
        forward_b = (mem_rw && mem_dest != '0 && mem_dest == ex_rt) ? 2'd2 :
                    (wb_rw && wb_dest != '0 && wb_dest == ex_rt) ? 2'd1 : 2'd0;
        load_use  = id_valid && ex_mr && ex_dest != '0 &&
                    ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
        stall     = load_use && !flush;
        bubble    = stall || flush || !id_valid;
    end

    assign pc_write   = ~stall;
    assign ifid_write = ~stall;

    // Shadow tag pipeline across ID/EX, EX/MEM and MEM/WB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_dest  <= '0;
            ex_rw    <= 1'b0;
            ex_mr    <= 1'b0;
            mem_dest <= '0;
            mem_rw   <= 1'b0;
            wb_dest  <= '0;
            wb_rw    <= 1'b0;
        end else begin
            wb_dest  <= mem_dest;
            wb_rw    <= mem_rw;
            mem_dest <= ex_dest;
            mem_rw   <= ex_rw;
            ex_rs    <= (bubble || !id_uses_rs) ? '0 : id_rs;
            ex_rt    <= (bubble || !id_uses_rt) ? '0 : id_rt;
            ex_dest  <= bubble ? '0 : id_dest;
            ex_rw    <= !bubble && id_reg_write;
            ex_mr    <= !bubble && id_mem_read;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed and random checks against an instruction-queue model
module tb_forward_hazard_unit;
    logic clock = 1'b0, reset = 1'b1;
    logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rs, id_rt, id_dest;
    logic [1:0] forward_a, forward_b, s_fa, s_fb;
    logic stall, pc_write, ifid_write, s_stall, s_pw, s_iw;
    logic [15:0] stall_count;
    logic [3:0] s_cnt;
    int tests = 0, fails = 0;

    typedef struct {logic [4:0] rs, rt, dest; logic rw, mr;} instr_t;
    instr_t pipe[3];  // [0]=EX, [1]=MEM, [2]=WB
    int m_cnt = 0;

    always #5 clock = ~clock;

    forward_hazard_unit u_dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .stall_count(stall_count)
    );

    // Narrow counter instance: reaches saturation within a short run
    forward_hazard_unit #(.STALL_CNT_WIDTH(4)) u_sat (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .forward_a(s_fa), .forward_b(s_fb), .stall(s_stall), .pc_write(s_pw),
        .ifid_write(s_iw), .stall_count(s_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest in-flight writer of r wins: MEM gives 2, WB gives 1
    function automatic int m_fwd(input logic [4:0] r);
        for (int i = 1; i <= 2; i++)
            if (r != 0 && pipe[i].rw && pipe[i].dest == r) return i == 1 ? 2 : 1;
        return 0;
    endfunction

    function automatic logic m_stall();
        instr_t e = pipe[0];
        return id_valid && e.mr && e.dest != 0 && !flush &&
               ((id_uses_rs && id_rs == e.dest) || (id_uses_rt && id_rt == e.dest));
    endfunction

    // Reference model: instruction queue advancing one slot per clock
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
            m_cnt = 0;
        end else begin
            logic st;
            st = m_stall();
            if (st) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st || flush || !id_valid) pipe[0] = '{0, 0, 0, 0, 0};
            else pipe[0] = '{id_uses_rs ? id_rs : 5'd0, id_uses_rt ? id_rt : 5'd0,
                             id_dest, id_reg_write, id_mem_read};
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            check("m_fwd_a", int'(forward_a), m_fwd(pipe[0].rs));
            check("m_fwd_b", int'(forward_b), m_fwd(pipe[0].rt));
            check("m_stall", int'(stall), int'(m_stall()));
            check("m_pc_write", int'(pc_write), int'(!m_stall()));
            check("m_ifid_write", int'(ifid_write), int'(!m_stall()));
            check("m_count", int'(stall_count), m_cnt > 65535 ? 65535 : m_cnt);
            check("m_sat_count", int'(s_cnt), m_cnt > 15 ? 15 : m_cnt);
        end
    end

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] d,
                         input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = d; id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        idle();
        #2;
        check("rst_fwd_a", int'(forward_a), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_pc_write", int'(pc_write), 1);
        check("rst_count", int'(stall_count), 0);
        tick();
        reset = 1'b0;
        // EX/MEM forward: add $8 ; sub rs=8 rt=9
        drive(1, 1, 2, 1, 1, 8, 1, 0, 0); tick();
        drive(1, 8, 9, 1, 1, 3, 1, 0, 0); tick();
        idle(); @(negedge clock);
        check("exmem_fwd_a", int'(forward_a), 2);
        check("exmem_fwd_b", int'(forward_b), 0);
        tick();
        // Double hazard: add $8 ; add $8 ; or rs=8
        drive(1, 1, 2, 1, 1, 8, 1, 0, 0); tick();
        drive(1, 3, 4, 1, 1, 8, 1, 0, 0); tick();
        drive(1, 8, 0, 1, 0, 6, 1, 0, 0); tick();
        idle(); @(negedge clock);
        check("double_fwd_a", int'(forward_a), 2);
        tick();
        // Unrelated instruction in between: forward from WB
        drive(1, 1, 2, 1, 1, 8, 1, 0, 0); tick();
        drive(1, 1, 2, 1, 1, 7, 1, 0, 0); tick();
        drive(1, 8, 0, 1, 0, 6, 1, 0, 0); tick();
        idle(); @(negedge clock);
        check("wb_fwd_a", int'(forward_a), 1);
        tick();
        // Load-use: lw $10 ; add rt=10
        do_reset();
        drive(1, 1, 0, 1, 0, 10, 1, 1, 0); tick();
        drive(1, 3, 10, 1, 1, 11, 1, 0, 0); @(negedge clock);
        check("lu_stall", int'(stall), 1);
        check("lu_pc_write", int'(pc_write), 0);
        check("lu_ifid_write", int'(ifid_write), 0);
        tick(); @(negedge clock);
        check("lu_stall_next", int'(stall), 0);
        tick(); idle(); @(negedge clock);
        check("lu_fwd_b", int'(forward_b), 1);
        check("lu_count", int'(stall_count), 1);
        tick();
        // $0 load never stalls
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 2, 1, 1, 4, 1, 0, 0); @(negedge clock);
        check("zero_stall", int'(stall), 0);
        tick(); idle(); @(negedge clock);
        check("zero_fwd_a", int'(forward_a), 0);
        tick();
        // Flush overrides load-use
        drive(1, 1, 0, 1, 0, 5, 1, 1, 0); tick();
        drive(1, 5, 0, 1, 0, 6, 1, 0, 1); @(negedge clock);
        check("flush_stall", int'(stall), 0);
        tick(); idle(); @(negedge clock);
        check("flush_fwd_a", int'(forward_a), 0);
        check("flush_fwd_b", int'(forward_b), 0);
        check("flush_count", int'(stall_count), 1);
        tick();
        // Reset mid-stream clears tags immediately
        drive(1, 1, 2, 1, 1, 8, 1, 0, 0); tick();
        drive(1, 8, 8, 1, 1, 9, 1, 0, 0); tick();
        idle(); @(negedge clock);
        check("pre_rst_fwd_a", int'(forward_a), 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_fwd_a", int'(forward_a), 0);
        check("mid_rst_fwd_b", int'(forward_b), 0);
        check("mid_rst_stall", int'(stall), 0);
        check("mid_rst_count", int'(stall_count), 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_fwd_a", int'(forward_a), 0);
        tick();
        // Random traffic with a small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            if (n < 1500 && $urandom_range(0, 299) == 0) do_reset();
            tick();
        end
        idle(); @(negedge clock);
        check("sat_count", int'(s_cnt), 15);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
